// File: rtl/sid_pkg.sv
// Shared state type, rate table and exponential-divider constants for the SID envelope.
package sid_pkg;

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_RELEASE = 2'd2
    } env_state_e;

    localparam int RATE_TAB_W = 15;

    // Tick count minus one between rate strobes, indexed by the 4-bit rate nibble.
    localparam logic [RATE_TAB_W-1:0] RATE_TABLE [16] = '{
        15'd8,    15'd31,   15'd62,   15'd94,
        15'd148,  15'd219,  15'd266,  15'd312,
        15'd391,  15'd976,  15'd1953, 15'd3125,
        15'd3906, 15'd11719, 15'd19531, 15'd31250
    };

    localparam logic [7:0] EXP_THR_P1  = 8'h5E;
    localparam logic [7:0] EXP_THR_P2  = 8'h37;
    localparam logic [7:0] EXP_THR_P4  = 8'h1B;
    localparam logic [7:0] EXP_THR_P8  = 8'h0F;
    localparam logic [7:0] EXP_THR_P16 = 8'h07;

    localparam logic [4:0] EXP_PER_1  = 5'd1;
    localparam logic [4:0] EXP_PER_2  = 5'd2;
    localparam logic [4:0] EXP_PER_4  = 5'd4;
    localparam logic [4:0] EXP_PER_8  = 5'd8;
    localparam logic [4:0] EXP_PER_16 = 5'd16;
    localparam logic [4:0] EXP_PER_30 = 5'd30;

    // Piecewise approximation of the exponential decay curve.
    function automatic logic [4:0] exp_period(input logic [7:0] env);
        if (env >= EXP_THR_P1)       return EXP_PER_1;
        else if (env >= EXP_THR_P2)  return EXP_PER_2;
        else if (env >= EXP_THR_P4)  return EXP_PER_4;
        else if (env >= EXP_THR_P8)  return EXP_PER_8;
        else if (env >= EXP_THR_P16) return EXP_PER_16;
        else                         return EXP_PER_30;
    endfunction

endpackage

// File: rtl/sid_env_rate.sv
// Linear rate counter for the SID envelope; produces one strobe per selected rate period.
// Define SID_ENV_RATE_BUG_EN to reproduce the original equality-only compare (ADSR delay bug).
module sid_env_rate
    import sid_pkg::*;
#(
    parameter int RATE_W = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic [3:0] rate_idx_i,
    output logic       rate_stb_o
);

    logic [RATE_W-1:0] cnt_q;
    logic [RATE_W-1:0] cnt_d;
    logic [RATE_W-1:0] target;
    logic              match;

    assign target = RATE_W'(RATE_TABLE[rate_idx_i]);

`ifdef SID_ENV_RATE_BUG_EN
    // A switch to a shorter rate lets the count overshoot and run the full wrap.
    assign match = (cnt_q == target);
`else
    assign match = (cnt_q >= target);
`endif

    always_comb begin
        cnt_d      = cnt_q;
        rate_stb_o = 1'b0;
        if (tick_i) begin
            if (match) begin
                cnt_d      = '0;
                rate_stb_o = 1'b1;
            end else begin
                cnt_d = cnt_q + RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sid_envelope.sv
// SID ADSR envelope generator: gate edge detect, state machine, exponential divider, level register.
// Rate-counter behaviour is selected by SID_ENV_RATE_BUG_EN (see sid_env_rate).
module sid_envelope
    import sid_pkg::*;
#(
    parameter int RATE_W = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iTick,
    input  logic       iGate,
    input  logic [3:0] iAttack,
    input  logic [3:0] iDecay,
    input  logic [3:0] iSustain,
    input  logic [3:0] iRelease,
    output logic [7:0] oEnv,
    output logic [1:0] oState
);

    env_state_e state_q, state_d;
    logic [7:0] env_q, env_d;
    logic [4:0] div_q, div_d;
    logic       gprev_q;

    logic       rise;
    logic       fall;
    logic       rate_stb;
    logic       div_run;
    logic       exp_stb;
    logic [3:0] rate_idx;
    logic [7:0] sus_lvl;
    logic [4:0] div_inc;

    always_comb begin
        case (state_q)
            ST_ATTACK: rate_idx = iAttack;
            ST_DECAY:  rate_idx = iDecay;
            default:   rate_idx = iRelease;
        endcase
    end

    sid_env_rate #(
        .RATE_W(RATE_W)
    ) u_rate (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (iTick),
        .rate_idx_i(rate_idx),
        .rate_stb_o(rate_stb)
    );

    assign rise    = iGate & ~gprev_q;
    assign fall    = ~iGate & gprev_q;
    assign sus_lvl = {iSustain, iSustain};
    assign div_inc = div_q + 5'd1;

    // Attack bypasses the divider; a finished release freezes it.
    assign div_run = rate_stb && (state_q != ST_ATTACK)
                     && !((state_q == ST_RELEASE) && (env_q == 8'h00));
    assign exp_stb = div_run && (div_inc >= exp_period(env_q));

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        div_d   = div_q;
        if (rise) begin
            state_d = ST_ATTACK;
            div_d   = '0;
        end else if (fall) begin
            state_d = ST_RELEASE;
        end else begin
            if (div_run) begin
                div_d = exp_stb ? 5'd0 : div_inc;
            end
            case (state_q)
                ST_ATTACK: begin
                    if (rate_stb) begin
                        if (env_q != 8'hFF) begin
                            env_d = env_q + 8'd1;
                        end
                        if (env_q >= 8'hFE) begin
                            state_d = ST_DECAY;
                        end
                    end
                end
                ST_DECAY: begin
                    // Levels at or below sustain hold; raising sustain never re-attacks.
                    if (exp_stb && (env_q > sus_lvl)) begin
                        env_d = env_q - 8'd1;
                    end
                end
                default: begin
                    if (exp_stb) begin
                        env_d = env_q - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RELEASE;
            env_q   <= 8'h00;
            div_q   <= 5'd0;
            gprev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            div_q   <= div_d;
            gprev_q <= iGate;
        end
    end

    assign oEnv   = env_q;
    assign oState = state_q;

endmodule

// File: doc/sid_envelope.md
# sid_envelope

Per-voice ADSR envelope generator reproducing the SID envelope behaviour. It produces the 8-bit envelope level that drives the `iEnv` input of the 12x8 voice-envelope multiplier (`mdac12x8`), directly downstream. It advances on a 1 MHz SID-tick enable and holds the envelope in a state machine with a linear rate counter and an exponential decay/release divider.

## Interface
Parameters:
- `RATE_W`, 15: rate counter width in bits.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `iTick`, in, 1: one-cycle SID tick enable (1 MHz equivalent). All counting happens only on tick cycles.
- `iGate`, in, 1: voice gate bit from the control register.
- `iAttack`, in, 4: attack rate index.
- `iDecay`, in, 4: decay rate index.
- `iSustain`, in, 4: sustain level nibble.
- `iRelease`, in, 4: release rate index.
- `oEnv`, out, 8: envelope level, registered. Feeds `mdac12x8.iEnv`.
- `oState`, out, 2: current state (ATTACK=0, DECAY=1, RELEASE=2), for debug and readback.

## Operation
- **Gate edge detection.**
  - A registered previous gate, `gPrev`, is reset to 0.
  - Rising edge (`iGate & ~gPrev`) sets the state to ATTACK. Falling edge sets it to RELEASE. Edge detection is evaluated every clk, independent of `iTick`.
  - If the gate is already high when reset deasserts, that counts as a rising edge.
- **Rate select.**
  - The rate index comes from `iAttack`, `iDecay` or `iRelease`, chosen by state.
  - The index maps through a 16-entry table: 8, 31, 62, 94, 148, 219, 266, 312, 391, 976, 1953, 3125, 3906, 11719, 19531, 31250.
- **Rate counter** (`RATE_W` bits).
  - On each tick, if the counter matches the selected table value, the counter clears to 0 and a rate strobe fires. Otherwise the counter increments.
  - The step period is therefore table+1 ticks.
- **Exponential divider** (5 bits).
  - The period is selected by the current `oEnv`:
    - ≥0x5E: 1
    - 0x37–0x5D: 2
    - 0x1B–0x36: 4
    - 0x0F–0x1A: 8
    - 0x07–0x0E: 16
    - 0x01–0x06: 30
  - On each rate strobe the divider increments. When it reaches its period it clears and fires an exp strobe.
  - The divider clears on entry to ATTACK.
- **ATTACK.**
  - On a rate strobe, `oEnv` increments; the exp divider is bypassed.
  - When `oEnv` reaches 0xFF, the state becomes DECAY on the same cycle. `oEnv` never wraps past 0xFF.
- **DECAY.**
  - On an exp strobe, `oEnv` decrements, unless `oEnv` equals the sustain level `{iSustain,iSustain}` (0x11×s).
  - At the sustain level it holds. If `iSustain` changes above the current level, it holds; there is no re-attack.
- **RELEASE.**
  - On an exp strobe, `oEnv` decrements toward 0.
  - At 0 it holds, and the divider stops.
- **Simultaneous events.**
  - A gate edge on a strobe cycle: the state change wins, and no envelope step occurs that cycle.
  - The rate counter is never cleared by a gate edge.
- **Reset mid-operation.** Reset returns every register to its reset value on the next clk, regardless of state.

## Timing
- Reset values:
  - `oEnv` = 0x00
  - `oState` = RELEASE
  - rate counter = 0
  - exp divider = 0
  - `gPrev` = 0
- `oEnv` updates one clk after the tick that produces the strobe. Strobes are combinational from the counters on the tick cycle.
- `oState` updates one clk after the gate edge.
- Parameter changes on `iAttack`, `iDecay`, `iRelease` and `iSustain` take effect on the next tick. They need no handshake.
- End to end: `mdac12x8` adds one further registered cycle, so voice output reflects `oEnv` 2 clk later.

## Configuration
- `SID_ENV_RATE_BUG_EN` defined:
  - The rate counter matches on equality only, reproducing the SID ADSR delay bug.
  - Switching to a rate whose table value is below the current count makes the counter run to 2^`RATE_W`−1, wrap to 0, then match. This delays the next step by up to 32768 ticks.
- Undefined: the counter matches on `count >= table value`, so the strobe fires on the next tick after such a switch.

## Structure
- Shared package (`sid_pkg`) holds:
  - the state enum (ATTACK/DECAY/RELEASE)
  - the 16-entry rate table constant
  - the exponential threshold and period constants
- Sub-module `sid_env_rate`: the rate counter, table lookup and bug option, producing a rate strobe. Instantiated once.
- The top level holds the gate edge detection, the state machine, the exp divider and the `oEnv` register.

## Test plan
- **Attack:** `iTick` every clk, attack=0, gate 0→1 → `oEnv` 0→0xFF in 255×9 = 2295 ticks; state becomes DECAY on the cycle `oEnv` = 0xFF.
- **Decay to sustain:** decay=0, sustain=0xA after full attack → `oEnv` descends 0xFF→0xAA in 85 steps of 9 ticks, then holds 0xAA for ≥10000 ticks.
- **Release:** release=0 from 0xAA, gate 1→0 → exp periods observed as 1/2/4/8/16/30 across the thresholds; `oEnv` reaches 0 and holds; divider frozen.
- **Gate-off mid-attack:** gate low at `oEnv` = 0x40 → state RELEASE next clk, `oEnv` decrements from 0x40 with period-2 spacing.
- **Rate bug:** attack=15 run to count 5000, then attack=0. With `SID_ENV_RATE_BUG_EN`, the next step comes after 32768−5000+9 ticks. Without it, the step comes on the next tick.
- **Mid-operation reset:** `rst` pulse in DECAY at `oEnv` = 0xC0 → next clk `oEnv` = 0, state RELEASE. Gate held high across reset → ATTACK one clk after `rst` falls.
